gridworld_episode_ctrl: RTL
===========================

# gridworld_episode_ctrl

Sequential episode controller for the 8x8 gridworld used in the spec-inference experiments. It owns the agent position and applies one 3-bit compass action per handshake using the standard wall-saturating step rule. It senses the colour of each visited cell and evaluates the fixed task monitor online: avoid red, reach yellow, and after any brown visit reach blue before yellow. It replaces the unrolled fixed-horizon step chain for streaming and bench-driven episodes.

## Interface
- HORIZON, 18: maximum number of actions per episode; must be in 1..255.
- CW, $clog2(HORIZON+1): width of the step counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  episode start request; sampled in IDLE or DONE only.
- x0  input  3  start x coordinate, captured with start.
- y0  input  3  start y coordinate, captured with start.
- act_valid  input  1  action offered.
- act  input  3  compass action code.
- act_ready  output  1  controller accepts an action this cycle.
- x  output  3  current x position.
- y  output  3  current y position.
- colors  output  4  colours of the current cell: [0]=red, [1]=brown, [2]=yellow, [3]=blue.
- step_cnt  output  CW  number of actions applied this episode.
- busy  output  1  high in CHECK or RUN.
- done  output  1  high in DONE.
- result  output  2  valid when done: 00=pass, 01=fail red, 10=fail yellow reached while brown pending, 11=fail timeout.

## Operation
- States: IDLE, CHECK, RUN, DONE.
- IDLE/DONE with start=1: load x<=x0, y<=y0, step_cnt<=0, pending<=0, then go to CHECK. In DONE, result is cleared to 00 on the restart.
- CHECK evaluates the current cell in strict priority order:
  - red: result 01, go to DONE.
  - yellow with pending=1: result 10, go to DONE.
  - yellow with pending=0: result 00, go to DONE.
  - otherwise, blue clears pending, then brown sets pending.
  - then, if step_cnt==HORIZON: result 11, go to DONE; else go to RUN.
- RUN: act_ready=1. On act_valid&act_ready, apply the action to x,y, increment step_cnt, and go to CHECK.
- Action decode for the x axis: 0 and 4 hold, 1..3 add 1, 5..7 subtract 1.
- Action decode for the y axis: 2 and 6 hold, 7/0/1 add 1, 3..5 subtract 1.
- Walls: any move that would leave 0..7 holds that axis; there is no modular wrap.
- An action applied at a wall still counts as a step.
- Colour regions:
  - blue: x in 3..4 and y in 2..5.
  - yellow: x in {0,7} and y in {0,7}.
  - brown: x in 2..5 and y in {0,7}.
  - red: (x in {1,6} and y in {0,1,4,5}) or (x in {0,7} and y in {1,4,5}).
- colors is combinational from the x,y registers; the regions are disjoint.
- start is ignored in CHECK and RUN.
- act_valid is ignored outside RUN. act is not stored while act_ready=0.
- pending is internal; it is cleared by reset and by start.

## Timing
- Reset values: IDLE, x=0, y=0, step_cnt=0, pending=0, result=00, act_ready=0, busy=0, done=0. colors reflects (0,0), i.e. 0100.
- Reset mid-episode aborts on the next edge; no result is produced.
- Start to first act_ready: 2 cycles (start edge loads position, CHECK edge enters RUN).
- Action accepted to new x,y visible: 1 cycle. Verdict, or the next act_ready, follows 1 cycle later.
- Throughput: at most one action per 2 cycles.
- done and result hold until rst or an accepted start.
- Start on a resolving cell gives done 2 cycles after start with step_cnt=0; act_ready is never asserted.

## Test plan
- Pass with a brown detour: start (3,0), actions 0,0,0,0,0,0,6,6,6,0.
  - Blue is visited at (3,2); the last position is (0,7).
  - Required: result=00, step_cnt=10, done asserted.
- Red: start (3,0), actions 6,6 (via (2,0) brown to (1,0)).
  - Required: result=01, step_cnt=2, x=1, y=0.
- Wall hold and timeout: start (0,2), action 6 repeated.
  - Required: x,y stay (0,2); step_cnt counts up; result=11 at step_cnt=18.
  - Required: act_ready is low after the 18th accept.
- Pending violation: start (2,7), actions 6,6 (to (1,7), then (0,7)).
  - Required: result=10, step_cnt=2.
- Immediate verdict: start (7,7).
  - Required: done at cycle 2, result=00, step_cnt=0, act_ready never high.
- Robustness: assert start during RUN, and act_valid during CHECK; both must be ignored.
  - Then assert rst after 3 steps. Required: all outputs return to the reset values on the next edge.

Source files
------------

// File: rtl/gridworld_episode_ctrl.sv
// Episode controller for the 8x8 gridworld: owns the agent position, applies one
// wall-saturating compass action per handshake and evaluates the task monitor online.
module gridworld_episode_ctrl #(
    parameter int HORIZON = 18,
    parameter int CW      = $clog2(HORIZON + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    x0,
    input  logic [2:0]    y0,
    input  logic          act_valid,
    input  logic [2:0]    act,
    output logic          act_ready,
    output logic [2:0]    x,
    output logic [2:0]    y,
    output logic [3:0]    colors,
    output logic [CW-1:0] step_cnt,
    output logic          busy,
    output logic          done,
    output logic [1:0]    result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] HORIZON_C = CW'(HORIZON);

    // Colour bits are {blue, yellow, brown, red}; the regions never overlap.
    function automatic logic [3:0] cell_colors(input logic [2:0] cx, input logic [2:0] cy);
        logic red_v, brown_v, yellow_v, blue_v;
        blue_v   = (cx == 3'd3 || cx == 3'd4) && (cy >= 3'd2 && cy <= 3'd5);
        yellow_v = (cx == 3'd0 || cx == 3'd7) && (cy == 3'd0 || cy == 3'd7);
        brown_v  = (cx >= 3'd2 && cx <= 3'd5) && (cy == 3'd0 || cy == 3'd7);
        red_v    = ((cx == 3'd1 || cx == 3'd6) &&
                    (cy == 3'd0 || cy == 3'd1 || cy == 3'd4 || cy == 3'd5)) ||
                   ((cx == 3'd0 || cx == 3'd7) &&
                    (cy == 3'd1 || cy == 3'd4 || cy == 3'd5));
        return {blue_v, yellow_v, brown_v, red_v};
    endfunction

    // One axis step; a move past either wall leaves the coordinate unchanged.
    function automatic logic [2:0] axis_step(input logic [2:0] pos, input logic inc, input logic dec);
        logic [2:0] nxt;
        if (inc && pos != 3'd7) begin
            nxt = pos + 3'd1;
        end else if (dec && pos != 3'd0) begin
            nxt = pos - 3'd1;
        end else begin
            nxt = pos;
        end
        return nxt;
    endfunction

    state_t        state_r, state_nxt_s;
    logic [2:0]    x_r, y_r;
    logic [CW-1:0] step_cnt_r;
    logic          pending_r;
    logic [1:0]    result_r;
    logic [3:0]    colors_s;
    logic          chk_done_s, chk_pending_s;
    logic [1:0]    chk_result_s;
    logic [2:0]    x_step_s, y_step_s;

    assign colors_s = cell_colors(x_r, y_r);
    assign x_step_s = axis_step(x_r, act >= 3'd1 && act <= 3'd3, act >= 3'd5);
    assign y_step_s = axis_step(y_r, act == 3'd7 || act <= 3'd1, act >= 3'd3 && act <= 3'd5);

    // Monitor verdict for the current cell, in priority order red > yellow > pending update > horizon.
    always_comb begin
        chk_done_s    = 1'b0;
        chk_result_s  = 2'b00;
        chk_pending_s = pending_r;
        if (colors_s[0]) begin
            chk_done_s   = 1'b1;
            chk_result_s = 2'b01;
        end else if (colors_s[2]) begin
            chk_done_s   = 1'b1;
            chk_result_s = pending_r ? 2'b10 : 2'b00;
        end else begin
            if (colors_s[3]) begin
                chk_pending_s = 1'b0;
            end else if (colors_s[1]) begin
                chk_pending_s = 1'b1;
            end else begin
                chk_pending_s = pending_r;
            end
            if (step_cnt_r == HORIZON_C) begin
                chk_done_s   = 1'b1;
                chk_result_s = 2'b11;
            end else begin
                chk_done_s   = 1'b0;
                chk_result_s = 2'b00;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) state_nxt_s = S_CHECK;
                else       state_nxt_s = state_r;
            end
            S_CHECK: begin
                if (chk_done_s) state_nxt_s = S_DONE;
                else            state_nxt_s = S_RUN;
            end
            S_RUN: begin
                if (act_valid) state_nxt_s = S_CHECK;
                else           state_nxt_s = S_RUN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Position, step count, pending flag and verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r        <= 3'd0;
            y_r        <= 3'd0;
            step_cnt_r <= '0;
            pending_r  <= 1'b0;
            result_r   <= 2'b00;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        x_r        <= x0;
                        y_r        <= y0;
                        step_cnt_r <= '0;
                        pending_r  <= 1'b0;
                        result_r   <= 2'b00;
                    end
                end
                S_CHECK: begin
                    pending_r <= chk_pending_s;
                    if (chk_done_s) result_r <= chk_result_s;
                end
                S_RUN: begin
                    if (act_valid) begin
                        x_r        <= x_step_s;
                        y_r        <= y_step_s;
                        step_cnt_r <= step_cnt_r + CW'(1);
                    end
                end
                default: begin
                    x_r <= x_r;
                end
            endcase
        end
    end

    // Outputs decoded from the state register and datapath registers.
    always_comb begin
        act_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            S_CHECK: busy = 1'b1;
            S_RUN: begin
                busy      = 1'b1;
                act_ready = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign x        = x_r;
    assign y        = y_r;
    assign colors   = colors_s;
    assign step_cnt = step_cnt_r;
    assign result   = result_r;

endmodule
